if_fetch_stage: RTL
===================

# if_fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline. Holds the program counter, drives the instruction-memory address, and captures the fetched word plus PC+4 into IF/ID. The stage sits directly upstream of the hazard stalling unit. It supplies that unit's `if_id_Rs`/`if_id_Rt` operands and consumes its `stall` output. It also accepts a branch/jump redirect that flushes the wrong-path instruction.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Bits [1:0] must be 0.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall`  in  3  from the stalling unit; any nonzero value means stall
- `flush`  in  1  taken branch/jump redirect
- `branch_target`  in  32  redirect PC; bits [1:0] are ignored and treated as 0
- `imem_addr`  out  32  instruction-memory address; equals the current PC
- `imem_rdata`  in  32  instruction word, combinational read of `imem_addr`
- `if_id_pc4`  out  32  registered PC+4 of the instruction held in IF/ID
- `if_id_instr`  out  32  registered instruction; 32'h0 (NOP) when invalid
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `if_id_Rs`  out  5  `if_id_instr[25:21]`
- `if_id_Rt`  out  5  `if_id_instr[20:16]`
- `id_ex_bubble`  out  1  combinational `|stall`; the ID/EX control mux uses it to zero control signals

## Operation
- PC register update, applied each edge in this priority order:
  1. `rst`: PC ← `RESET_PC`.
  2. `flush`: PC ← {`branch_target[31:2]`, 2'b00}.
  3. `stall` ≠ 0: PC holds.
  4. Otherwise: PC ← PC + 4.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000. Bits [1:0] of PC are always 0.
- IF/ID register update, applied each edge:
  - `rst` or `flush`: `if_id_instr` ← 0, `if_id_pc4` ← 0, `if_id_valid` ← 0.
  - `stall` ≠ 0 (and no flush): all IF/ID fields hold.
  - Otherwise: `if_id_instr` ← `imem_rdata`, `if_id_pc4` ← PC + 4, `if_id_valid` ← 1.
- `if_id_Rs` and `if_id_Rt` are pure slices of `if_id_instr`. When invalid, both read 0.
- Flush and stall asserted together: flush wins. PC takes the redirect target, IF/ID is cleared, and the stall is dropped.
- A stall held for N cycles freezes PC and IF/ID for exactly N edges. No instruction is lost or duplicated.
- No state machine beyond the PC and IF/ID registers. The block is a two-register pipeline with hold/clear controls.

## Timing
- Reset values: PC = `RESET_PC`, `imem_addr` = `RESET_PC`, `if_id_instr` = 0, `if_id_pc4` = 0, `if_id_valid` = 0, `if_id_Rs` = `if_id_Rt` = 0. `id_ex_bubble` follows `stall` combinationally, including during reset.
- Reset is asynchronous. Outputs take reset values immediately on `rst` rising, independent of `clk`. The first fetch edge is the first rising edge after `rst` deasserts.
- Latency: the word at address A, fetched while PC = A, appears on `if_id_instr` one edge later, with `if_id_pc4` = A + 4.
- Flush penalty: one bubble. In the edge where `flush`=1, IF/ID becomes invalid. The target instruction appears in IF/ID one edge after that.
- `stall` and `flush` are sampled at the edge. Only their values in the cycle before the edge matter.
- Reset mid-stall or mid-flush: reset overrides both, and no pending state survives.

## Configuration
- `FETCH_PERF_EN` defined adds two outputs, `perf_stall_cnt[15:0]` and `perf_flush_cnt[15:0]`:
  - `perf_stall_cnt` increments on each edge where `stall` ≠ 0 and `flush` = 0.
  - `perf_flush_cnt` increments on each edge where `flush` = 1.
  - Both saturate at 16'hFFFF and reset to 0.
- `FETCH_PERF_EN` undefined: the ports and counters do not exist, and fetch behaviour is identical.

## Test plan
- Reset then run with `RESET_PC`=0 and `imem_rdata` = 32'h2000_0000 | addr. After 3 edges: PC = 12, `if_id_instr` = 32'h2000_0008, `if_id_pc4` = 12, `if_id_valid` = 1.
- With PC = 8, hold `stall`=3'b001 for 2 edges. PC stays 8 and IF/ID is unchanged for both edges. The edge after the stall drops gives PC = 12 and loads instr@8. `id_ex_bubble` = 1 only during the stall.
- With PC = 16, assert `flush` with `branch_target` = 32'h0000_0103. Next edge: PC = 32'h0000_0100, `if_id_valid` = 0, `if_id_instr` = 0. The edge after: `if_id_instr` = instr@0x100.
- Assert `flush` and `stall`=1 in the same cycle with target 0x40. Flush wins: PC = 0x40 and IF/ID is cleared.
- Set PC = 32'hFFFF_FFFC by redirect, then run one free edge. PC = 0 and `if_id_pc4` = 0.
- Assert `rst` asynchronously between edges while IF/ID is valid. Outputs go to reset values before the next edge. With `FETCH_PERF_EN` defined, 3 stall edges and 1 flush edge give counts 3 and 1.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register plus IF/ID pipeline register with stall hold and flush redirect.
// Optional FETCH_PERF_EN adds saturating stall/flush event counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  stall,
    input  logic        flush,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [4:0]  if_id_Rs,
    output logic [4:0]  if_id_Rt,
    output logic        id_ex_bubble
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stalled;

    assign stalled      = |stall;
    assign pc_plus4     = pc + 32'd4;
    assign imem_addr    = pc;
    assign id_ex_bubble = stalled;
    assign if_id_Rs     = if_id_instr[25:21];
    assign if_id_Rt     = if_id_instr[20:16];

    // Flush outranks stall so a redirect is never lost behind a hazard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (flush) begin
            pc <= {branch_target[31:2], 2'b00};
        end else if (!stalled) begin
            pc <= pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else if (flush) begin
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else if (!stalled) begin
            if_id_instr <= imem_rdata;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stalled && !flush && perf_stall_cnt != 16'hFFFF)
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            if (flush && perf_flush_cnt != 16'hFFFF)
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
        end
    end
`endif

endmodule
